// File: rtl/sseg_pkg.sv
// sseg_pkg: shared segment patterns, blank constant and anode helper for hex_sseg_mux
// Contents: SEG_0..SEG_F (abcdefg, active-low), SEG_TABLE (nibble-indexed),
//           SSEG_OFF (all segments and dp dark), an_onehot_low() (one-hot-low anode vector)
package sseg_pkg;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_TABLE [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };
    localparam logic [7:0] SSEG_OFF = 8'hFF;
    function automatic logic [7:0] an_onehot_low(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction
endpackage

// File: rtl/hex_sseg_mux_if.sv
// hex_sseg_mux_if: datapath-to-display bundle for hex_sseg_mux
// Signals: hex (packed nibbles, digit 0 rightmost), dp_en, blank (per digit, from datapath);
//          an (active-low anodes), sseg ({dp,a..g} active-low), frame_tick (to datapath/pins)
// Modports: master = datapath side, slave = display driver side
interface hex_sseg_mux_if #(parameter int N_DIGITS = 4);
    logic [4*N_DIGITS-1:0] hex;
    logic [N_DIGITS-1:0]   dp_en;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   an;
    logic [7:0]            sseg;
    logic                  frame_tick;
    modport master (output hex, dp_en, blank, input an, sseg, frame_tick);
    modport slave (input hex, dp_en, blank, output an, sseg, frame_tick);
endinterface

// File: rtl/sseg_hex_lut.sv
// sseg_hex_lut: combinational hex nibble to abcdefg (active-low) decoder
// Ports: nib (4-bit hex digit in), seg (7-bit abcdefg pattern out)
module sseg_hex_lut
    import sseg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/hex_sseg_mux.sv
// hex_sseg_mux: time-multiplexed N-digit common-anode seven-segment driver
// Ports: clk, reset (sync, active-high), bus (hex_sseg_mux_if.slave: hex/dp_en/blank in,
//        an/sseg/frame_tick registered out)
// Option: define HEX_SSEG_LZB_EN for leading-zero blanking of digits 1..N_DIGITS-1
module hex_sseg_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_BITS = 18
) (
    input  logic            clk,
    input  logic            reset,
    hex_sseg_mux_if.slave   bus
);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);

    logic [REFRESH_BITS-1:0] pre_q, pre_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [N_DIGITS-1:0]     an_q, an_d, lzb;
    logic [7:0]              sseg_q, sseg_d, an_full;
    logic                    frame_q, frame_d, tick, off;
    logic [3:0]              nib;
    logic [6:0]              seg;

    assign nib = bus.hex[4*int'(idx_q) +: 4];

    sseg_hex_lut u_lut (.nib(nib), .seg(seg));

`ifdef HEX_SSEG_LZB_EN
    logic lzb_run;
    // Walk down from the most significant digit; a digit is dark while every nibble
    // at or above it is zero and it has no dp of its own. Digit 0 is never touched.
    always_comb begin
        lzb     = '0;
        lzb_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lzb_run = lzb_run & (bus.hex[4*i +: 4] == 4'h0);
            lzb[i]  = lzb_run & ~bus.dp_en[i];
        end
    end
`else
    assign lzb = '0;
`endif

    // Output registers sample the current idx, so on a tick cycle the old digit is
    // loaded and the new digit reaches an/sseg together one clock after idx moves.
    always_comb begin
        tick    = &pre_q;
        pre_d   = pre_q + 1'b1;
        idx_d   = tick ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
        an_full = an_onehot_low(3'(idx_q));
        an_d    = an_full[N_DIGITS-1:0];
        off     = bus.blank[idx_q] | lzb[idx_q];
        sseg_d  = off ? SSEG_OFF : {~bus.dp_en[idx_q], seg};
        frame_d = tick & (idx_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            sseg_q  <= SSEG_OFF;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            frame_q <= frame_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
    assign bus.frame_tick = frame_q;
endmodule

// File: tb/tb_hex_sseg_mux.sv
// tb_hex_sseg_mux: scoreboard bench for hex_sseg_mux with 4-digit and 3-digit instances
module tb_hex_sseg_mux;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hx = 16'h3210;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  bl = 4'h0;

    always #5 clk = ~clk;

    hex_sseg_mux_if #(.N_DIGITS(4)) if4 ();
    hex_sseg_mux_if #(.N_DIGITS(3)) if3 ();

    assign if4.hex   = hx;
    assign if4.dp_en = dp;
    assign if4.blank = bl;
    assign if3.hex   = hx[11:0];
    assign if3.dp_en = dp[2:0];
    assign if3.blank = bl[2:0];

    hex_sseg_mux #(.N_DIGITS(4), .REFRESH_BITS(2)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    hex_sseg_mux #(.N_DIGITS(3), .REFRESH_BITS(2)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    localparam logic [6:0] TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] ss;
        logic       ft;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;
    int checks = 0;
    int errors = 0;
    int pre4 = 0, idx4 = 0, pre3 = 0, idx3 = 0;

    function automatic void chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endfunction

    // Expected register contents after the coming clock edge, given present inputs.
    task automatic model(input int n, inout int pre, inout int idx, output exp_t e);
        logic [7:0] mask;
        logic [7:0] lz;
        logic       off;
        mask = 8'((1 << n) - 1);
        lz   = 8'h00;
        if (reset) begin
            e.an = mask;
            e.ss = 8'hFF;
            e.ft = 1'b0;
            pre  = 0;
            idx  = 0;
        end else begin
`ifdef HEX_SSEG_LZB_EN
            begin
                logic z;
                z = 1'b1;
                for (int i = n - 1; i >= 1; i--) begin
                    z     = z & (hx[4*i +: 4] == 4'h0);
                    lz[i] = z & ~dp[i];
                end
            end
`endif
            off  = bl[idx] | lz[idx];
            e.an = mask & ~(8'h01 << idx);
            e.ss = off ? 8'hFF : {~dp[idx], TBL[hx[4*idx +: 4]]};
            e.ft = (pre == 3) && (idx == n - 1);
            if (pre == 3) idx = (idx == n - 1) ? 0 : idx + 1;
            pre = (pre + 1) % 4;
        end
    endtask

    task automatic cyc();
        exp_t e;
        model(4, pre4, idx4, e);
        q4.push_back(e);
        model(3, pre3, idx3, e);
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q4.size() != 0) begin
            e4 = q4.pop_front();
            chk("an4", {4'h0, if4.an}, e4.an);
            chk("sseg4", if4.sseg, e4.ss);
            chk("frame4", {7'h00, if4.frame_tick}, {7'h00, e4.ft});
        end
        if (q3.size() != 0) begin
            e3 = q3.pop_front();
            chk("an3", {5'h00, if3.an}, e3.an);
            chk("sseg3", if3.sseg, e3.ss);
            chk("frame3", {7'h00, if3.frame_tick}, {7'h00, e3.ft});
        end
    end

    logic [15:0] sweep [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};

    initial begin
        repeat (3) cyc();
        reset = 1'b0;
        repeat (32) cyc();
        for (int v = 0; v < 4; v++) begin
            hx = sweep[v];
            repeat (16) cyc();
        end
        dp = 4'b0101;
        bl = 4'b1000;
        hx = 16'h8888;
        repeat (16) cyc();
        bl = 4'b1111;
        repeat (16) cyc();
        dp = 4'b0000;
        bl = 4'b0000;
        hx = 16'h0050;
        repeat (16) cyc();
        hx = 16'h0000;
        repeat (16) cyc();
        hx = 16'h4321;
        for (int k = 0; k < 64 && !(idx4 == 2 && pre4 == 1); k++) cyc();
        checks++;
        if (!(idx4 == 2 && pre4 == 1)) begin
            errors++;
            $display("FAIL midscan_reach: idx %0d pre %0d expected idx 2 pre 1", idx4, pre4);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        repeat (24) cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_sseg_mux.md
# hex_sseg_mux

Time-multiplexed driver for an N-digit common-anode seven-segment display. It accepts N packed hex nibbles plus per-digit decimal-point and blank controls. A free-running prescaler scans one digit at a time. For the active digit it drives registered, active-low anode and segment outputs. It sits between the datapath (counters, debug registers) and the board display pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_BITS`, 18: prescaler width; each digit is held for 2^REFRESH_BITS clocks.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-high. One clock domain only.
- `hex`  in  4*N_DIGITS  packed nibbles; digit i is `hex[4i+3:4i]`, and digit 0 is the rightmost.
- `dp_en`  in  N_DIGITS  1 lights the decimal point of digit i.
- `blank`  in  N_DIGITS  1 turns off all segments and the dp of digit i; the anode still scans.
- `an`  out  N_DIGITS  anode enables, active-low, one-hot-low.
- `sseg`  out  8  `{dp,a,b,c,d,e,f,g}`, active-low.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

## Operation
- Prescaler `pre` counts 0..2^REFRESH_BITS-1 and wraps to 0.
  - `tick` = (`pre` == all ones).
- Digit index `idx` (width max(1, clog2(N_DIGITS))):
  - On `tick`, `idx` increments.
  - At N_DIGITS-1 it wraps to 0. This explicit wrap is required for non-power-of-two N.
  - With N_DIGITS=1, `idx` stays 0.
- Every cycle the output registers load the following from the current `idx` and the live inputs:
  - `an`: bit `idx` = 0, all other bits = 1.
  - `sseg[6:0]`: decode of nibble `idx`, or 7'b1111111 if `blank[idx]`.
  - `sseg[7]`: `~dp_en[idx]`, or 1 if `blank[idx]`.
- Decode table, abcdefg active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - E and F are distinct codes.
- `frame_tick` is registered. It is 1 in the cycle after a `tick` in which `idx` was N_DIGITS-1.
- Inputs are not latched. An input change appears on the outputs one clock later, even mid-digit.

## Timing
- Reset values:
  - `pre`=0, `idx`=0.
  - `an`=all ones (display dark).
  - `sseg`=8'hFF.
  - `frame_tick`=0.
- In the first clock after `reset` deasserts, the outputs show digit 0.
- Latency from input to pins is 1 clock.
- Dwell per digit is exactly 2^REFRESH_BITS clocks. A full frame is N_DIGITS·2^REFRESH_BITS clocks.
- On a `tick` cycle, the output register samples the old `idx`. The new digit appears on `an`/`sseg` one clock after `idx` changes. `an` and `sseg` always switch in the same clock, so there is never a mixed digit.
- Reset asserted mid-scan:
  - Takes effect on the next clock edge regardless of `pre`/`idx`.
  - No `frame_tick` is emitted for the aborted frame.
- Asserting `blank` on every digit leaves `an` scanning and holds `sseg`=8'hFF.

## Configuration
- `HEX_SSEG_LZB_EN` defined: leading-zero blanking.
  - Digit i (i≥1) is treated as blanked when every nibble i..N_DIGITS-1 is 0 and `dp_en[i]` is 0.
  - Digit 0 is never suppressed.
  - This is ORed with `blank`.
- `HEX_SSEG_LZB_EN` undefined: zeros always display. The suppression logic is absent.

## Structure
- Package `sseg_pkg`:
  - Segment pattern constants for 0..F.
  - The all-off constant 8'hFF.
  - A function returning the one-hot-low anode vector for an index.
- Sub-module `sseg_hex_lut`: combinational nibble→abcdefg lookup. It is instantiated once, on the muxed nibble.
- Top level holds the prescaler, index counter, optional LZB mask, and output registers.

## Test plan
- Reset and dwell:
  - Setup: REFRESH_BITS=2, N_DIGITS=4, hold `reset` 3 cycles, then release.
  - Reset: `an`=4'b1111 and `sseg`=8'hFF during reset.
  - Scan: `an`=1110 for 4 clocks, then 1101, 1011, 0111, then back to 1110.
  - Frame: `frame_tick` pulses once per 16 clocks.
- Decode sweep:
  - Stimulus: `hex`=16'hFEDC, then 16'hBA98, 16'h7654, 16'h3210.
  - Response: each digit's `sseg[6:0]` matches the table. Digit 2 of FEDC gives 0110000 (E); digit 3 gives 0111000 (F).
- DP and blank:
  - Stimulus: `dp_en`=4'b0101, `blank`=4'b1000, `hex`=16'h8888.
  - Response: digits 0 and 2 show `sseg`=8'h00; digit 1 shows 8'h80; digit 3 shows 8'hFF with `an`=0111.
- Non-power-of-two wrap:
  - Stimulus: N_DIGITS=3.
  - Response: `idx` sequence 0,1,2,0; `an` never equals 3'b111 after reset; `frame_tick` every 3·2^REFRESH_BITS clocks.
- Mid-scan reset:
  - Stimulus: assert `reset` while `idx`=2 and `pre`=1.
  - Response: next clock gives `an`=all ones; after release, digit 0 holds for a full dwell.
- LZB (`HEX_SSEG_LZB_EN` defined):
  - `hex`=16'h0050: digits 3 and 2 give `sseg`=8'hFF; digit 1 shows 5; digit 0 shows 0.
  - `hex`=16'h0000: only digit 0 shows 0.
